// File: rtl/shared_mem_ctrl.sv
// Main-memory controller behind the shared bus: fixed-latency reads, FLUSH writebacks, 1-entry read buffer.
// Define MEM_STATS_EN to add rd_count / wr_count saturating counters and the sticky drop_seen flag.
module shared_mem_ctrl #(
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 8,
    parameter int READ_LAT = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [2:0]        bus_cmd,
    input  logic [ADDR_W-1:0] bus_addr,
    input  logic [DATA_W-1:0] bus_data,
    input  logic [1:0]        bus_owner,
    output logic [DATA_W-1:0] mem_data,
    output logic              mem_valid,
    output logic [1:0]        resp_owner,
    output logic              mem_busy,
    output logic              drop_err
`ifdef MEM_STATS_EN
    ,
    output logic [15:0]       rd_count,
    output logic [15:0]       wr_count,
    output logic              drop_seen
`endif
);
    localparam int DEPTH = 2**ADDR_W;
    localparam logic [3:0] LAT_INIT = (READ_LAT >= 2) ? 4'(READ_LAT - 2) : 4'd0;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [1:0]        owner;
    } req_t;

    logic [DATA_W-1:0] mem [DEPTH];
    state_t            state, state_nxt;
    logic [3:0]        lat_cnt, lat_nxt;
    logic              req_vld, buf_vld, buf_vld_nxt;
    req_t              req_q, buf_q, buf_nxt, cur_q, cur_nxt, start_src, rsp_src;
    logic              do_start, drop;
    logic              is_rd, is_flush;
    logic [DATA_W-1:0] rd_data;

    assign is_rd    = (bus_cmd == 3'd1) || (bus_cmd == 3'd2);
    assign is_flush = (bus_cmd == 3'd4);

    assign mem_valid = (state == S_RESP);
    assign mem_busy  = buf_vld && (state != S_RESP);

    // A FLUSH landing on the RESP-entry edge must be visible to the read being answered.
    assign rd_data = (is_flush && (bus_addr == rsp_src.addr)) ? bus_data : mem[rsp_src.addr];

    always_comb begin
        state_nxt   = state;
        lat_nxt     = lat_cnt;
        cur_nxt     = cur_q;
        buf_vld_nxt = buf_vld;
        buf_nxt     = buf_q;
        do_start    = 1'b0;
        start_src   = req_q;
        rsp_src     = cur_q;
        drop        = 1'b0;
        case (state)
            S_IDLE: if (req_vld) do_start = 1'b1;
            S_WAIT: begin
                if (lat_cnt == 4'd0) state_nxt = S_RESP;
                else                 lat_nxt   = lat_cnt - 4'd1;
                if (req_vld) begin
                    if (!buf_vld) begin
                        buf_vld_nxt = 1'b1;
                        buf_nxt     = req_q;
                    end else begin
                        drop = 1'b1;
                    end
                end
            end
            S_RESP: begin
                state_nxt = S_IDLE;
                if (buf_vld) begin
                    // Buffered read goes first; a read arriving now refills the freed slot.
                    do_start    = 1'b1;
                    start_src   = buf_q;
                    buf_vld_nxt = req_vld;
                    buf_nxt     = req_q;
                end else if (req_vld) begin
                    do_start = 1'b1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
        if (do_start) begin
            cur_nxt = start_src;
            if (READ_LAT == 1) begin
                state_nxt = S_RESP;
                rsp_src   = start_src;
            end else begin
                state_nxt = S_WAIT;
                lat_nxt   = LAT_INIT;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            lat_cnt    <= '0;
            req_vld    <= 1'b0;
            req_q      <= '0;
            buf_vld    <= 1'b0;
            buf_q      <= '0;
            cur_q      <= '0;
            mem_data   <= '0;
            resp_owner <= '0;
            drop_err   <= 1'b0;
        end else begin
            state    <= state_nxt;
            lat_cnt  <= lat_nxt;
            req_vld  <= is_rd;
            req_q    <= '{addr: bus_addr, owner: bus_owner};
            buf_vld  <= buf_vld_nxt;
            buf_q    <= buf_nxt;
            cur_q    <= cur_nxt;
            drop_err <= drop;
            if (state_nxt == S_RESP) begin
                mem_data   <= rd_data;
                resp_owner <= rsp_src.owner;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (is_flush) begin
            mem[bus_addr] <= bus_data;
        end
    end

`ifdef MEM_STATS_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_count  <= '0;
            wr_count  <= '0;
            drop_seen <= 1'b0;
        end else begin
            if (mem_valid && (rd_count != 16'hFFFF)) rd_count <= rd_count + 16'd1;
            if (is_flush && (wr_count != 16'hFFFF))  wr_count <= wr_count + 16'd1;
            if (drop) drop_seen <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_shared_mem_ctrl.sv
// Bench for shared_mem_ctrl: directed scenarios plus random traffic against an edge-timed reference model.
module tb_shared_mem_ctrl;
    localparam int ADDR_W   = 8;
    localparam int DATA_W   = 8;
    localparam int READ_LAT = 3;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [2:0]        bus_cmd = '0;
    logic [ADDR_W-1:0] bus_addr = '0;
    logic [DATA_W-1:0] bus_data = '0;
    logic [1:0]        bus_owner = '0;
    logic [DATA_W-1:0] mem_data;
    logic              mem_valid;
    logic [1:0]        resp_owner;
    logic              mem_busy;
    logic              drop_err;
`ifdef MEM_STATS_EN
    logic [15:0]       rd_count, wr_count;
    logic              drop_seen;
`endif

    always #5 clk = ~clk;

    shared_mem_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .READ_LAT(READ_LAT)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus_cmd   (bus_cmd),
        .bus_addr  (bus_addr),
        .bus_data  (bus_data),
        .bus_owner (bus_owner),
        .mem_data  (mem_data),
        .mem_valid (mem_valid),
        .resp_owner(resp_owner),
        .mem_busy  (mem_busy),
        .drop_err  (drop_err)
`ifdef MEM_STATS_EN
        ,
        .rd_count  (rd_count),
        .wr_count  (wr_count),
        .drop_seen (drop_seen)
`endif
    );

    int checks = 0;
    int errors = 0;

    // Reference model: reads are timed by absolute edge numbers, not by an FSM.
    logic [DATA_W-1:0] marr [2**ADDR_W];
    int                n;
    bit                inflight;
    int                resp_edge;
    logic [ADDR_W-1:0] cur_addr, buf_addr, arr_addr;
    logic [1:0]        cur_owner, buf_owner, arr_owner;
    bit                buf_v, arr_v;
    bit                exp_valid, exp_drop, exp_busy, exp_seen;
    logic [DATA_W-1:0] exp_data;
    logic [1:0]        exp_owner;
    int                exp_rd, exp_wr;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2**ADDR_W; i++) marr[i] = '0;
        n = 0; inflight = 0; resp_edge = 0;
        buf_v = 0; arr_v = 0;
        cur_addr = '0; cur_owner = '0; buf_addr = '0; buf_owner = '0; arr_addr = '0; arr_owner = '0;
        exp_valid = 0; exp_drop = 0; exp_busy = 0; exp_seen = 0;
        exp_data = '0; exp_owner = '0; exp_rd = 0; exp_wr = 0;
    endtask

    task automatic model_start(input logic [ADDR_W-1:0] a, input logic [1:0] o);
        inflight  = 1;
        resp_edge = n + READ_LAT - 1;
        cur_addr  = a;
        cur_owner = o;
    endtask

    // A read sampled at edge k is served from edge k+1; its answer appears READ_LAT edges after k.
    task automatic model_edge();
        n++;
        exp_drop = 0;
        if (exp_valid && exp_rd < 65535) exp_rd++;
        if (inflight && n == resp_edge + 1) begin
            inflight = 0;
            if (buf_v) begin
                model_start(buf_addr, buf_owner);
                buf_v = 0;
            end
        end
        if (arr_v) begin
            if (!inflight) model_start(arr_addr, arr_owner);
            else if (!buf_v) begin
                buf_v = 1; buf_addr = arr_addr; buf_owner = arr_owner;
            end else begin
                exp_drop = 1; exp_seen = 1;
            end
        end
        if (bus_cmd == 3'd4) begin
            marr[bus_addr] = bus_data;
            if (exp_wr < 65535) exp_wr++;
        end
        exp_valid = inflight && (n == resp_edge);
        if (exp_valid) begin
            exp_data  = marr[cur_addr];
            exp_owner = cur_owner;
        end
        exp_busy  = buf_v && !exp_valid;
        arr_v     = (bus_cmd == 3'd1) || (bus_cmd == 3'd2);
        arr_addr  = bus_addr;
        arr_owner = bus_owner;
    endtask

    task automatic check_all();
        check("mem_valid",  mem_valid,  exp_valid);
        check("mem_busy",   mem_busy,   exp_busy);
        check("drop_err",   drop_err,   exp_drop);
        check("mem_data",   mem_data,   exp_data);
        check("resp_owner", resp_owner, exp_owner);
`ifdef MEM_STATS_EN
        check("rd_count",   rd_count,   exp_rd);
        check("wr_count",   wr_count,   exp_wr);
        check("drop_seen",  drop_seen,  exp_seen);
`endif
    endtask

    // Called at a negedge; returns at the following negedge.
    task automatic step(input logic [2:0] cmd, input logic [7:0] addr,
                        input logic [7:0] data, input logic [1:0] owner);
        bus_cmd = cmd; bus_addr = addr; bus_data = data; bus_owner = owner;
        @(posedge clk);
        model_edge();
        #1 check_all();
        @(negedge clk);
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) step(3'd0, 8'h00, 8'h00, 2'b00);
    endtask

    task automatic do_reset();
        bus_cmd = '0;
        rst = 1'b0;
        #1;
        model_reset();
        check_all();
        @(posedge clk);
        #1 check_all();
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        int          r;
        logic [2:0]  c;
        @(negedge clk);
        do_reset();

        // Plain read of a reset location
        step(3'd1, 8'h10, 8'h00, 2'b01);
        idle(3);
        check("t1_valid", mem_valid, 1);
        check("t1_data",  mem_data,  8'h00);
        check("t1_owner", resp_owner, 2'b01);
        idle(2);

        // FLUSH then RDX of the same line
        step(3'd4, 8'h22, 8'hA5, 2'b00);
        step(3'd2, 8'h22, 8'h00, 2'b10);
        idle(3);
        check("t2_valid", mem_valid, 1);
        check("t2_data",  mem_data,  8'hA5);
        check("t2_owner", resp_owner, 2'b10);
        idle(2);

        // Back-to-back reads, third one dropped
        step(3'd4, 8'h02, 8'h5C, 2'b00);
        step(3'd1, 8'h01, 8'h00, 2'b01);
        step(3'd1, 8'h02, 8'h00, 2'b10);
        step(3'd1, 8'h03, 8'h00, 2'b01);
        check("t3_busy",  mem_busy, 1);
        idle(1);
        check("t3_valid1", mem_valid, 1);
        check("t3_busy_resp", mem_busy, 0);
        check("t3_drop", drop_err, 1);
        check("t3_owner1", resp_owner, 2'b01);
        idle(1);
        check("t3_drop_clr", drop_err, 0);
        check("t3_valid_clr", mem_valid, 0);
        idle(2);
        check("t3_valid2", mem_valid, 1);
        check("t3_data2", mem_data, 8'h5C);
        check("t3_owner2", resp_owner, 2'b10);
        idle(4);

        // FLUSH on the RESP-entry edge is forwarded
        step(3'd1, 8'h30, 8'h00, 2'b01);
        idle(2);
        step(3'd4, 8'h30, 8'h5A, 2'b00);
        check("t4_valid", mem_valid, 1);
        check("t4_fwd",   mem_data,  8'h5A);
        idle(2);

        // Reset in the middle of a read
        step(3'd1, 8'h22, 8'h00, 2'b01);
        idle(1);
        do_reset();
        idle(5);
        check("t5_no_valid", mem_valid, 0);
        step(3'd1, 8'h22, 8'h00, 2'b10);
        idle(3);
        check("t5_valid", mem_valid, 1);
        check("t5_data_cleared", mem_data, 8'h00);
        check("t5_owner", resp_owner, 2'b10);
        idle(2);

        // Random traffic on a narrow address window to force collisions
        for (int i = 0; i < 800; i++) begin
            r = $urandom_range(0, 99);
            if (r < 30)      c = 3'd1;
            else if (r < 45) c = 3'd2;
            else if (r < 52) c = 3'd3;
            else if (r < 75) c = 3'd4;
            else if (r < 80) c = 3'($urandom_range(5, 7));
            else             c = 3'd0;
            if ($urandom_range(0, 299) == 0) do_reset();
            step(c, 8'($urandom_range(0, 7)), 8'($urandom), ($urandom_range(0, 1) != 0) ? 2'b01 : 2'b10);
        end
        idle(8);

`ifdef MEM_STATS_EN
        do_reset();
        step(3'd4, 8'h05, 8'h11, 2'b00);
        step(3'd4, 8'h06, 8'h22, 2'b00);
        step(3'd1, 8'h05, 8'h00, 2'b01);
        idle(4);
        step(3'd2, 8'h06, 8'h00, 2'b10);
        idle(4);
        step(3'd1, 8'h07, 8'h00, 2'b01);
        idle(6);
        check("s_wr2", wr_count, 16'd2);
        check("s_rd3", rd_count, 16'd3);
        for (int i = 0; i < 65540; i++) step(3'd4, 8'(i), 8'(i), 2'b00);
        check("s_wr_sat", wr_count, 16'hFFFF);
        idle(2);
        check("s_wr_hold", wr_count, 16'hFFFF);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/shared_mem_ctrl.md
Name: shared_mem_ctrl

Overview:
- Main-memory controller sitting directly downstream of the shared bus; consumes the bus's broadcast command/address stream (cmd_out, addr_out, bus_owner).
- Services BUS_RD/BUS_RDX with a fixed-latency data response, absorbs FLUSH writebacks into a DEPTH x DATA_W array, ignores BUS_UPGR.
- Holds one pending read in a 1-entry buffer while a read is in flight.

Parameters:
- ADDR_W, 8, address width; DEPTH = 2**ADDR_W.
- DATA_W, 8, data width.
- READ_LAT, 3, cycles from read accept edge to mem_valid; legal range 1..15.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-low reset (0 = reset).
- bus_cmd  input  3  0 IDLE, 1 BUS_RD, 2 BUS_RDX, 3 BUS_UPGR, 4 FLUSH; 5-7 treated as IDLE.
- bus_addr  input  ADDR_W  command address.
- bus_data  input  DATA_W  writeback data, valid with FLUSH.
- bus_owner  input  2  one-hot requester of the current command.
- mem_data  output  DATA_W  read response data.
- mem_valid  output  1  one-cycle response strobe.
- resp_owner  output  2  bus_owner captured with the request being answered.
- mem_busy  output  1  read buffer full; a new read this cycle will be dropped.
- drop_err  output  1  one-cycle pulse, read dropped.

Behaviour:
- Reset (rst=0, asynchronous):
  - array cleared to 0; state IDLE; buffer empty.
  - mem_data=0, mem_valid=0, resp_owner=0, mem_busy=0, drop_err=0.
  - Asserted mid-read: the read is aborted and no mem_valid is produced after release.
- FLUSH:
  - Written to array[bus_addr] at the sampling edge in any state.
  - Never stalls, never buffered, no response.
- BUS_UPGR and IDLE: no action.
- Reads (BUS_RD or BUS_RDX, identical handling): sampled at a rising edge; capture {addr, owner}.
- FSM states IDLE, WAIT, RESP; lat_cnt is 4 bits.
  - IDLE + read: READ_LAT=1 -> RESP; else -> WAIT with lat_cnt=READ_LAT-2.
  - WAIT: lat_cnt decrements each cycle; at lat_cnt==0 -> RESP.
  - RESP (one cycle, mem_valid=1):
    - buffer valid -> start buffered read (same rules as from IDLE), buffer cleared;
    - else incoming read -> start it;
    - else -> IDLE.
- Read accepted while in WAIT/RESP: goes to the buffer if empty.
  - RESP with a buffer pop and a new read on the same edge: the new read refills the buffer.
- Buffer full and another read arrives (outside the RESP-pop case): read discarded, drop_err pulses next cycle.
- mem_busy = buffer valid && !(state==RESP); registered-state decode, no input paths.
- Response timing:
  - mem_valid rises exactly READ_LAT cycles after the accept edge for an unbuffered read.
  - mem_data, resp_owner are loaded on the edge entering RESP and held until the next RESP entry.
  - mem_valid and drop_err deassert after one cycle.
- Read data is taken from the array at the edge entering RESP, so earlier FLUSHes are visible.
- FLUSH to the same address on that same edge: forwarded, mem_data = bus_data.
- Address arithmetic: no wrap logic needed; full ADDR_W range is valid.

Optional Feature:
- Macro: MEM_STATS_EN.
- Defined:
  - Adds outputs rd_count[15:0] and wr_count[15:0], reset to 0.
  - rd_count increments per mem_valid; wr_count increments per FLUSH.
  - Both saturate at 16'hFFFF.
  - A drop also sets sticky output drop_seen, cleared only by reset.
- Not defined: those ports and logic are absent; all other behaviour is identical.

Test Plan:
- Reset, then BUS_RD addr 0x10, owner 2'b01 at t0 -> at t0+3: mem_valid=1, mem_data=0x00, resp_owner=2'b01.
- FLUSH addr 0x22 data 0xA5, then BUS_RDX addr 0x22 owner 2'b10 -> 3 cycles later mem_data=0xA5, resp_owner=2'b10.
- Back-to-back reads 0x01 (t0) and 0x02 (t0+1):
  - responses at t0+3 and t0+6; mem_busy=1 from t0+2 through t0+2 (not in RESP t0+3).
  - A third read at t0+2 -> drop_err pulse at t0+3, no response for it.
- Read 0x30 at t0, FLUSH 0x30 data 0x5A at edge t0+3 (RESP entry) -> mem_data=0x5A at t0+3.
- Read issued, rst=0 at t0+1, released at t0+2 -> mem_valid stays 0; a new read returns normally.
- With MEM_STATS_EN: 2 FLUSH + 3 reads -> wr_count=2, rd_count=3; counters hold at 16'hFFFF when forced to saturation.
